// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared region type and default 640x480@60 raster constants
package vga_timing_pkg;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vga_region_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_sync_generator_axis_timer.sv
// rtl/vga_sync_generator_axis_timer.sv - one raster axis: counter, region FSM and wrap pulse
module vga_axis_timer #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = 10
) (
    input  logic                          clkin,
    input  logic                          reset,
    input  logic                          advance,
    output logic [CW-1:0]                 count,
    output vga_timing_pkg::vga_region_e   region,
    output logic                          wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST_ACTIVE = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] LAST_FRONT  = CW'(ACTIVE + FP - 1);
    localparam logic [CW-1:0] LAST_SYNC   = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] LAST        = CW'(TOTAL - 1);

    vga_timing_pkg::vga_region_e region_next;

    // Pulses on the edge where the counter returns to zero.
    assign wrap = advance && (count == LAST);

    always_comb begin
        region_next = region;
        case (region)
            vga_timing_pkg::ACTIVE: if (count == LAST_ACTIVE) region_next = vga_timing_pkg::FRONT;
            vga_timing_pkg::FRONT:  if (count == LAST_FRONT)  region_next = vga_timing_pkg::SYNC;
            vga_timing_pkg::SYNC:   if (count == LAST_SYNC)   region_next = vga_timing_pkg::BACK;
            vga_timing_pkg::BACK:   if (count == LAST)        region_next = vga_timing_pkg::ACTIVE;
            default:                region_next = vga_timing_pkg::ACTIVE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            count  <= '0;
            region <= vga_timing_pkg::ACTIVE;
        end else if (advance) begin
            count  <= wrap ? '0 : count + 1'b1;
            region <= region_next;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - raster counters, sync, active-video and boundary strobes
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CW       = 10
) (
    input  logic          clkin,
    input  logic          reset,
    input  logic          ce,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          frame_start,
    output logic          line_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);

    logic [CW-1:0] h_count, v_count;
    vga_region_e   h_region, v_region;
    logic          h_wrap, v_wrap;
    logic          at_origin;

    // The timers run one pixel ahead; the output stage below registers their
    // decode so every output lines up with the hcount/vcount it presents.
    vga_axis_timer #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_htimer (
        .clkin(clkin), .reset(reset), .advance(ce),
        .count(h_count), .region(h_region), .wrap(h_wrap)
    );

    vga_axis_timer #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_vtimer (
        .clkin(clkin), .reset(reset), .advance(ce & h_wrap),
        .count(v_count), .region(v_region), .wrap(v_wrap)
    );

    // at_origin marks that the timers currently sit at (0,0) of a new frame.
    always_ff @(posedge clkin) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            at_origin   <= 1'b1;
        end else if (ce) begin
            hcount      <= h_count;
            vcount      <= v_count;
            hsync       <= (h_region == SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_region == SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on    <= (h_region == ACTIVE) && (v_region == ACTIVE);
            frame_start <= at_origin;
            line_end    <= (h_count == H_LAST);
            at_origin   <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - randomized check of three generator configurations against a raster model
module tb_vga_sync_generator;

    localparam int N = 3;
    // Instance 0: default 640x480, active-low. Instances 1/2: tiny raster, low/high polarity.
    localparam int P_HA[N]  = '{640, 8, 8};
    localparam int P_HFP[N] = '{16, 2, 2};
    localparam int P_HS[N]  = '{96, 3, 3};
    localparam int P_HBP[N] = '{48, 2, 2};
    localparam int P_VA[N]  = '{480, 6, 6};
    localparam int P_VFP[N] = '{10, 2, 2};
    localparam int P_VS[N]  = '{2, 2, 2};
    localparam int P_VBP[N] = '{33, 3, 3};
    localparam int P_POL[N] = '{0, 0, 1};

    generate
        for (genvar g = 0; g < N; g++) begin : g_param_guard
            if (P_HA[g] == 0 || P_HFP[g] == 0 || P_HS[g] == 0 || P_HBP[g] == 0 ||
                P_VA[g] == 0 || P_VFP[g] == 0 || P_VS[g] == 0 || P_VBP[g] == 0) begin : g_bad
                initial $fatal(1, "illegal zero-length region in configuration %0d", g);
            end
        end
    endgenerate

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic [9:0] hc[N];
    logic [9:0] vc[N];
    logic       hs[N], vs[N], von[N], fs[N], le[N];

    always #20 clkin = ~clkin;

    vga_sync_generator dut (
        .clkin(clkin), .reset(reset), .ce(ce),
        .hcount(hc[0]), .vcount(vc[0]), .hsync(hs[0]), .vsync(vs[0]),
        .video_on(von[0]), .frame_start(fs[0]), .line_end(le[0])
    );

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) dut_small (
        .clkin(clkin), .reset(reset), .ce(ce),
        .hcount(hc[1]), .vcount(vc[1]), .hsync(hs[1]), .vsync(vs[1]),
        .video_on(von[1]), .frame_start(fs[1]), .line_end(le[1])
    );

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) dut_pol (
        .clkin(clkin), .reset(reset), .ce(ce),
        .hcount(hc[2]), .vcount(vc[2]), .hsync(hs[2]), .vsync(vs[2]),
        .video_on(von[2]), .frame_start(fs[2]), .line_end(le[2])
    );

    int checks = 0;
    int errors = 0;
    int mh[N], mv[N];
    bit mrst[N];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int htotal(input int i);
        return P_HA[i] + P_HFP[i] + P_HS[i] + P_HBP[i];
    endfunction

    function automatic int vtotal(input int i);
        return P_VA[i] + P_VFP[i] + P_VS[i] + P_VBP[i];
    endfunction

    // Model: raster position plus a "held in reset" flag; outputs follow from arithmetic on it.
    task automatic step(input bit r, input bit c);
        int xh, xv, xhs, xvs, xvo, xfs, xle;
        reset = r;
        ce    = c;
        @(posedge clkin);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                mrst[i] = 1'b1; mh[i] = 0; mv[i] = 0;
            end else if (c) begin
                if (mrst[i]) mrst[i] = 1'b0;
                else begin
                    mh[i]++;
                    if (mh[i] == htotal(i)) begin
                        mh[i] = 0;
                        mv[i]++;
                        if (mv[i] == vtotal(i)) mv[i] = 0;
                    end
                end
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            xh = mh[i];
            xv = mv[i];
            if (mrst[i]) begin
                xhs = 1 - P_POL[i]; xvs = 1 - P_POL[i];
                xvo = 0; xfs = 0; xle = 0;
            end else begin
                xhs = (xh >= P_HA[i] + P_HFP[i] && xh < P_HA[i] + P_HFP[i] + P_HS[i]) ? P_POL[i] : 1 - P_POL[i];
                xvs = (xv >= P_VA[i] + P_VFP[i] && xv < P_VA[i] + P_VFP[i] + P_VS[i]) ? P_POL[i] : 1 - P_POL[i];
                xvo = (xh < P_HA[i] && xv < P_VA[i]) ? 1 : 0;
                xfs = (xh == 0 && xv == 0) ? 1 : 0;
                xle = (xh == htotal(i) - 1) ? 1 : 0;
            end
            check($sformatf("hcount[%0d]", i), int'(hc[i]), xh);
            check($sformatf("vcount[%0d]", i), int'(vc[i]), xv);
            check($sformatf("hsync[%0d]", i), int'(hs[i]), xhs);
            check($sformatf("vsync[%0d]", i), int'(vs[i]), xvs);
            check($sformatf("video_on[%0d]", i), int'(von[i]), xvo);
            check($sformatf("frame_start[%0d]", i), int'(fs[i]), xfs);
            check($sformatf("line_end[%0d]", i), int'(le[i]), xle);
        end
    endtask

    initial begin
        int fs_cnt, vs_low_cnt, hs_low_cnt, guard;

        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("release_frame_start", int'(fs[0]), 1);
        check("release_video_on", int'(von[0]), 1);

        // Line 0 and into line 1 on the default raster; count hsync-low cycles on line 0.
        hs_low_cnt = 0;
        for (int k = 1; k < 800; k++) begin
            step(1'b0, 1'b1);
            if (hs[0] == 1'b0) hs_low_cnt++;
        end
        check("hsync_low_width", hs_low_cnt, 96);
        step(1'b0, 1'b1);
        check("line1_vcount", int'(vc[0]), 1);

        // ce toggling: counters advance every other cycle, hold otherwise.
        for (int k = 0; k < 3200; k++) step(1'b0, k[0] ? 1'b0 : 1'b1);

        // Mid-frame reset on the small raster, then one clean frame from (0,0).
        guard = 0;
        while (!(mh[1] == 5 && mv[1] == 4) && guard < 500) begin
            step(1'b0, 1'b1);
            guard++;
        end
        check("reach_midframe", (guard < 500) ? 1 : 0, 1);
        step(1'b1, 1'b1);
        check("midreset_hcount", int'(hc[1]), 0);
        step(1'b0, 1'b1);
        fs_cnt = 0;
        vs_low_cnt = 0;
        for (int k = 0; k < htotal(1) * vtotal(1); k++) begin
            step(1'b0, 1'b1);
            if (fs[1]) fs_cnt++;
            if (vs[1] == 1'b0) vs_low_cnt++;
        end
        check("frame_start_once", fs_cnt, 1);
        check("vsync_low_cycles", vs_low_cnt, P_VS[1] * htotal(1));

        // Random ce and sparse random resets.
        for (int k = 0; k < 30000; k++)
            step(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
